// File: rtl/jpeg_zigzag_rle_pkg.sv
// rtl/jpeg_zigzag_rle_pkg.sv - shared zigzag table, FSM states, symbol constants and cat()
// Contents:
//   BLOCK_N  coefficients per 8x8 block
//   RUN_W    width of the JPEG run field
//   state_t  encoder FSM states
//   ZZ       zigzag index -> raster index
//   cat()    JPEG magnitude category (bit length of a magnitude)
package jpeg_pkg;

    localparam int BLOCK_N = 64;
    localparam int RUN_W   = 4;

    localparam logic [RUN_W-1:0] ZRL_RUN  = 4'd15;
    localparam logic [4:0]       ZRL_SIZE = 5'd0;
    localparam logic [RUN_W-1:0] EOB_RUN  = 4'd0;
    localparam logic [4:0]       EOB_SIZE = 5'd0;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_DC,
        ST_AC,
        ST_ZRL,
        ST_EOB,
        ST_DONE
    } state_t;

    localparam logic [5:0] ZZ [BLOCK_N] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Position of the highest set bit plus one; cat(0) = 0.
    function automatic logic [4:0] cat(input logic [30:0] mag);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 31; i++) begin
            if (mag[i]) n = 5'(i + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/jpeg_zigzag_rle_if.sv
// rtl/jpeg_zigzag_rle_if.sv - coefficient input stream and symbol output stream bundle
// Signals:
//   coef_in/coef_valid/coef_ready      raster-order quantized coefficients
//   dc_clear                           zero the DC predictor
//   sym_valid/sym_ready                symbol handshake
//   sym_run/sym_size/sym_amp           run, category, amplitude bits
//   sym_is_dc/sym_eob                  symbol kind flags
//   block_done                         pulse after the last symbol of a block
// Modports:
//   slave   the encoder block (consumes coefficients, produces symbols)
//   master  the surrounding pipeline (quantizer + Huffman side)
interface jpeg_zigzag_rle_if #(
    parameter int COEF_W = 16
);
    import jpeg_pkg::*;

    logic signed [COEF_W-1:0] coef_in;
    logic                     coef_valid;
    logic                     coef_ready;
    logic                     dc_clear;
    logic                     sym_valid;
    logic                     sym_ready;
    logic [RUN_W-1:0]         sym_run;
    logic [4:0]               sym_size;
    logic [COEF_W-1:0]        sym_amp;
    logic                     sym_is_dc;
    logic                     sym_eob;
    logic                     block_done;

    modport slave (
        input  coef_in, coef_valid, dc_clear, sym_ready,
        output coef_ready, sym_valid, sym_run, sym_size, sym_amp,
               sym_is_dc, sym_eob, block_done
    );

    modport master (
        output coef_in, coef_valid, dc_clear, sym_ready,
        input  coef_ready, sym_valid, sym_run, sym_size, sym_amp,
               sym_is_dc, sym_eob, block_done
    );

endinterface

// File: rtl/jpeg_zigzag_rle_mag_cat.sv
// rtl/jpeg_zigzag_rle_mag_cat.sv - combinational JPEG category and amplitude of a signed value
// Ports:
//   i_x     signed value (DC difference or sign-extended AC coefficient)
//   o_size  magnitude category
//   o_amp   low o_size bits of the JPEG amplitude, upper bits zero
module jpeg_mag_cat
    import jpeg_pkg::*;
#(
    parameter int W = 17
) (
    input  logic signed [W-1:0] i_x,
    output logic [4:0]          o_size,
    output logic [W-2:0]        o_amp
);

    logic         w_neg;
    logic [W-1:0] w_mag;
    logic [W-2:0] w_adj;

    assign w_neg  = i_x[W-1];
    assign w_mag  = w_neg ? -i_x : i_x;
    assign o_size = cat(31'(w_mag));

    // Negative values send x-1 (one's complement of |x|); only the low bits
    // survive the mask, so the subtraction is done at the output width.
    assign w_adj = i_x[W-2:0] - (W-1)'(w_neg);

    always_comb begin
        o_amp = '0;
        for (int i = 0; i < W - 1; i++) begin
            o_amp[i] = w_adj[i] & (i < int'(o_size));
        end
    end

endmodule

// File: rtl/jpeg_zigzag_rle.sv
// rtl/jpeg_zigzag_rle.sv - 8x8 block buffer, zigzag scan and DC/AC run-length symbol generator
// Ports:
//   CLK_I  clock
//   RST_I  asynchronous active-high reset
//   bus    slave side of jpeg_zigzag_rle_if (coefficients in, symbols out)
module jpeg_zigzag_rle
    import jpeg_pkg::*;
#(
    parameter int COEF_W = 16
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    jpeg_zigzag_rle_if.slave   bus
);

    state_t r_state, w_state_nxt;

    logic [5:0]               r_wr_idx, w_wr_nxt;
    logic [5:0]               r_rd_idx, w_rd_nxt;
    logic [5:0]               r_run, w_run_nxt;
    logic signed [COEF_W-1:0] r_buf [BLOCK_N];
    logic signed [COEF_W-1:0] r_dc_pred;

    logic                     r_sym_valid;
    logic [RUN_W-1:0]         r_sym_run;
    logic [4:0]               r_sym_size;
    logic [COEF_W-1:0]        r_sym_amp;
    logic                     r_sym_is_dc;
    logic                     r_sym_eob;
    logic                     r_block_done;

    logic                     w_load;
    logic [RUN_W-1:0]         w_ld_run;
    logic [4:0]               w_ld_size;
    logic [COEF_W-1:0]        w_ld_amp;
    logic                     w_ld_dc;
    logic                     w_ld_eob;
    logic                     w_pred_upd;
    logic                     w_done_pulse;

    logic                     w_fill_we;
    logic                     w_can_load;
    logic                     w_last_idx;
    logic signed [COEF_W-1:0] w_ac_coef;
    logic signed [COEF_W-1:0] w_dc_coef;
    logic                     w_ac_nz;
    logic signed [COEF_W:0]   w_diff;
    logic signed [COEF_W:0]   w_cat_in;
    logic [4:0]               w_cat_size;
    logic [COEF_W-1:0]        w_cat_amp;

    assign w_fill_we  = (r_state == ST_FILL) && bus.coef_valid;
    // The output register can take a new symbol when empty or draining this cycle.
    assign w_can_load = !r_sym_valid || bus.sym_ready;
    assign w_last_idx = (r_rd_idx == 6'(BLOCK_N - 1));
    assign w_ac_coef  = r_buf[ZZ[r_rd_idx]];
    assign w_dc_coef  = r_buf[0];
    assign w_ac_nz    = (w_ac_coef != '0);
    assign w_diff     = {w_dc_coef[COEF_W-1], w_dc_coef} - {r_dc_pred[COEF_W-1], r_dc_pred};
    assign w_cat_in   = (r_state == ST_DC) ? w_diff : {w_ac_coef[COEF_W-1], w_ac_coef};

    jpeg_mag_cat #(.W(COEF_W + 1)) u_mag_cat (
        .i_x    (w_cat_in),
        .o_size (w_cat_size),
        .o_amp  (w_cat_amp)
    );

    always_ff @(posedge CLK_I) begin
        if (w_fill_we) r_buf[r_wr_idx] <= bus.coef_in;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_nxt     = r_wr_idx;
        w_rd_nxt     = r_rd_idx;
        w_run_nxt    = r_run;
        w_load       = 1'b0;
        w_ld_run     = '0;
        w_ld_size    = '0;
        w_ld_amp     = '0;
        w_ld_dc      = 1'b0;
        w_ld_eob     = 1'b0;
        w_pred_upd   = 1'b0;
        w_done_pulse = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                if (bus.coef_valid) begin
                    w_wr_nxt = r_wr_idx + 6'd1;
                    if (r_wr_idx == 6'(BLOCK_N - 1)) begin
                        w_state_nxt = ST_DC;
                        w_rd_nxt    = 6'd1;
                    end
                end
            end
            ST_DC: begin
                if (w_can_load) begin
                    w_load      = 1'b1;
                    w_ld_size   = w_cat_size;
                    w_ld_amp    = w_cat_amp;
                    w_ld_dc     = 1'b1;
                    w_pred_upd  = 1'b1;
                    w_state_nxt = ST_AC;
                end
            end
            ST_AC: begin
                if (!w_ac_nz) begin
                    // Zeros are absorbed one per cycle even while the output is stalled.
                    w_run_nxt = r_run + 6'd1;
                    w_rd_nxt  = r_rd_idx + 6'd1;
                    if (w_last_idx) w_state_nxt = ST_EOB;
                end else if (r_run >= 6'd16) begin
                    w_state_nxt = ST_ZRL;
                end else if (w_can_load) begin
                    w_load    = 1'b1;
                    w_ld_run  = r_run[RUN_W-1:0];
                    w_ld_size = w_cat_size;
                    w_ld_amp  = w_cat_amp;
                    w_run_nxt = '0;
                    w_rd_nxt  = r_rd_idx + 6'd1;
                    if (w_last_idx) w_state_nxt = ST_DONE;
                end
            end
            ST_ZRL: begin
                if (w_can_load) begin
                    w_load      = 1'b1;
                    w_ld_run    = ZRL_RUN;
                    w_ld_size   = ZRL_SIZE;
                    w_run_nxt   = r_run - 6'd16;
                    w_state_nxt = ST_AC;
                end
            end
            ST_EOB: begin
                if (w_can_load) begin
                    w_load      = 1'b1;
                    w_ld_run    = EOB_RUN;
                    w_ld_size   = EOB_SIZE;
                    w_ld_eob    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hold until the block's final symbol leaves the output register.
                if (r_sym_valid && bus.sym_ready) begin
                    w_done_pulse = 1'b1;
                    w_run_nxt    = '0;
                    w_rd_nxt     = '0;
                    w_state_nxt  = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state      <= ST_FILL;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_run        <= '0;
            r_dc_pred    <= '0;
            r_sym_valid  <= 1'b0;
            r_sym_run    <= '0;
            r_sym_size   <= '0;
            r_sym_amp    <= '0;
            r_sym_is_dc  <= 1'b0;
            r_sym_eob    <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_idx     <= w_wr_nxt;
            r_rd_idx     <= w_rd_nxt;
            r_run        <= w_run_nxt;
            r_block_done <= w_done_pulse;
            // A clear on the same edge as the DC update wins.
            if (bus.dc_clear)     r_dc_pred <= '0;
            else if (w_pred_upd)  r_dc_pred <= w_dc_coef;
            if (w_load) begin
                r_sym_valid <= 1'b1;
                r_sym_run   <= w_ld_run;
                r_sym_size  <= w_ld_size;
                r_sym_amp   <= w_ld_amp;
                r_sym_is_dc <= w_ld_dc;
                r_sym_eob   <= w_ld_eob;
            end else if (bus.sym_ready) begin
                r_sym_valid <= 1'b0;
            end
        end
    end

    assign bus.coef_ready = (r_state == ST_FILL);
    assign bus.sym_valid  = r_sym_valid;
    assign bus.sym_run    = r_sym_run;
    assign bus.sym_size   = r_sym_size;
    assign bus.sym_amp    = r_sym_amp;
    assign bus.sym_is_dc  = r_sym_is_dc;
    assign bus.sym_eob    = r_sym_eob;
    assign bus.block_done = r_block_done;

endmodule

// File: tb/tb_jpeg_zigzag_rle.sv
// tb/tb_jpeg_zigzag_rle.sv - scoreboard bench for jpeg_zigzag_rle
module tb_jpeg_zigzag_rle;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jpeg_zigzag_rle_if #(.COEF_W(16)) bus ();

    jpeg_zigzag_rle #(.COEF_W(16)) u_dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  run;
        logic [4:0]  size;
        logic [15:0] amp;
        logic        dc;
        logic        eob;
        logic        last;
    } sym_t;

    sym_t              exp_q [$];
    int                n_cmp = 0;
    int                n_err = 0;
    int                n_sym = 0;
    logic signed [15:0] blk [64];

    task automatic push(input logic [3:0] r, input logic [4:0] s, input logic [15:0] a,
                        input logic dc, input logic eob, input logic last);
        sym_t e;
        e.run = r; e.size = s; e.amp = a; e.dc = dc; e.eob = eob; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = '0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic feed(input int n);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < n && guard < 5000) begin
            @(posedge clk); #1;
            bus.coef_in    = blk[i];
            bus.coef_valid = 1'b1;
            @(negedge clk);
            if (bus.coef_ready) i++;
            guard++;
        end
        @(posedge clk); #1;
        bus.coef_valid = 1'b0;
        check("fill_accepted", 32'(i), 32'(n));
    endtask

    task automatic wait_fill();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.coef_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_fill_ready", 32'(bus.coef_ready), 32'd1);
    endtask

    // Monitor: pops one expectation per symbol handshake and checks
    // block_done timing and output stability under back-pressure.
    logic        exp_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [26:0] prev_f = '0;

    always @(negedge clk) begin
        logic [26:0] f;
        sym_t        e;
        f = {bus.sym_run, bus.sym_size, bus.sym_amp, bus.sym_is_dc, bus.sym_eob};
        if (rst) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (exp_done) begin
                n_cmp++;
                if (bus.block_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL block_done got=%b want=1", bus.block_done);
                end
                exp_done = 1'b0;
            end else if (bus.block_done) begin
                n_cmp++;
                n_err++;
                $display("FAIL block_done_spurious got=1 want=0");
            end
            if (prev_stall) begin
                n_cmp++;
                if (!bus.sym_valid || f !== prev_f) begin
                    n_err++;
                    $display("FAIL stall_hold got valid=%b fields=%h want valid=1 fields=%h",
                             bus.sym_valid, f, prev_f);
                end
            end
            if (bus.sym_valid && bus.sym_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sym_unexpected got fields=%h want none", f);
                end else begin
                    e = exp_q.pop_front();
                    if (f !== {e.run, e.size, e.amp, e.dc, e.eob}) begin
                        n_err++;
                        $display("FAIL sym[%0d] got run=%0d size=%0d amp=%h dc=%b eob=%b want run=%0d size=%0d amp=%h dc=%b eob=%b",
                                 n_sym, bus.sym_run, bus.sym_size, bus.sym_amp, bus.sym_is_dc, bus.sym_eob,
                                 e.run, e.size, e.amp, e.dc, e.eob);
                    end
                    if (e.last) exp_done = 1'b1;
                end
                n_sym++;
            end
            prev_stall = bus.sym_valid && !bus.sym_ready;
            prev_f     = f;
        end
    end

    initial begin
        int guard;
        bus.coef_in    = '0;
        bus.coef_valid = 1'b0;
        bus.dc_clear   = 1'b0;
        bus.sym_ready  = 1'b1;
        clear_blk();

        repeat (3) @(posedge clk);
        #1;
        check("rst_coef_ready", 32'(bus.coef_ready), 32'd1);
        check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
        check("rst_block_done", 32'(bus.block_done), 32'd0);
        check("rst_fields", 32'({bus.sym_run, bus.sym_size, bus.sym_amp, bus.sym_is_dc, bus.sym_eob}), 32'd0);
        rst = 1'b0;

        // All-zero block, predictor 0.
        clear_blk();
        push(4'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        push(4'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        feed(64);

        // DC 5 after pred 0: diff 5 -> size 3, amp 101.
        clear_blk(); blk[0] = 16'sd5;
        push(4'd0, 5'd3, 16'h5, 1'b1, 1'b0, 1'b0);
        push(4'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        feed(64);

        // DC 2 after pred 5: diff -3 -> size 2, amp 00.
        clear_blk(); blk[0] = 16'sd2;
        push(4'd0, 5'd2, 16'h0, 1'b1, 1'b0, 1'b0);
        push(4'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        feed(64);

        // Clear predictor while idle in FILL, then raster[1]=-1, raster[8]=3.
        wait_fill();
        @(posedge clk); #1; bus.dc_clear = 1'b1;
        @(posedge clk); #1; bus.dc_clear = 1'b0;
        clear_blk(); blk[1] = -16'sd1; blk[8] = 16'sd3;
        push(4'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        push(4'd0, 5'd1, 16'h0, 1'b0, 1'b0, 1'b0);
        push(4'd0, 5'd2, 16'h3, 1'b0, 1'b0, 1'b0);
        push(4'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        feed(64);

        // Zigzag index 40 (raster 29) = 1: 39 zeros -> ZRL, ZRL, run 7.
        clear_blk(); blk[29] = 16'sd1;
        push(4'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        push(4'd15, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        push(4'd15, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        push(4'd7, 5'd1, 16'h1, 1'b0, 1'b0, 1'b0);
        push(4'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        feed(64);

        // raster[63] = -2: 62 zeros -> three ZRLs, run 14, no EOB.
        clear_blk(); blk[63] = -16'sd2;
        push(4'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        push(4'd15, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        push(4'd15, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        push(4'd15, 5'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        push(4'd14, 5'd2, 16'h1, 1'b0, 1'b0, 1'b1);
        feed(64);

        // DC 7, raster[1]=4, raster[8]=-5, with a 5-cycle stall after the DC.
        clear_blk(); blk[0] = 16'sd7; blk[1] = 16'sd4; blk[8] = -16'sd5;
        push(4'd0, 5'd3, 16'h7, 1'b1, 1'b0, 1'b0);
        push(4'd0, 5'd3, 16'h4, 1'b0, 1'b0, 1'b0);
        push(4'd0, 5'd3, 16'h2, 1'b0, 1'b0, 1'b0);
        push(4'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        feed(64);
        guard = 0;
        @(negedge clk);
        while (!(bus.sym_valid && bus.sym_is_dc) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("stall_dc_seen", 32'(bus.sym_valid && bus.sym_is_dc), 32'd1);
        @(posedge clk); #1; bus.sym_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_valid_held", 32'(bus.sym_valid), 32'd1);
        bus.sym_ready = 1'b1;

        // Partial fill, then reset: nothing may come out of the discarded block.
        wait_fill();
        for (int i = 0; i < 64; i++) blk[i] = 16'sd9;
        feed(30);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_coef_ready", 32'(bus.coef_ready), 32'd1);
        check("rst2_sym_valid", 32'(bus.sym_valid), 32'd0);
        check("rst2_block_done", 32'(bus.block_done), 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(bus.sym_valid), 32'd0);

        // Fresh block after reset: predictor back to 0, DC -1 -> size 1, amp 0.
        clear_blk(); blk[0] = -16'sd1;
        push(4'd0, 5'd1, 16'h0, 1'b1, 1'b0, 1'b0);
        push(4'd0, 5'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        feed(64);

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        repeat (5) @(posedge clk);
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_coef_ready", 32'(bus.coef_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
